// File: rtl/tetris_pkg.sv
// Shared types and helpers for the playfield controller.
//   state_t   : controller FSM states
//   anchor_t  : signed (row, col) anchor, signed so candidates one step
//               past a wall can be represented and rejected
//   cell_idx  : (r,c) -> flat playfield index r*cols+c
package tetris_pkg;
  localparam int ROWS_DEF = 10;
  localparam int COLS_DEF = 10;

  typedef enum logic [2:0] {
    SPAWN, FALL, LOCK, CLEAR_SCAN, CLEAR_SHIFT, GAME_OVER
  } state_t;

  typedef struct packed {
    logic signed [7:0] r;
    logic signed [7:0] c;
  } anchor_t;

  function automatic int cell_idx(input int r, input int c, input int cols = COLS_DEF);
    return r * cols + c;
  endfunction
endpackage

// File: rtl/piece_drop_ctrl_if.sv
// Control/status bundle of piece_drop_ctrl.
//   downTrue/moveLeft/moveRight/start : one-cycle requests into the block
//   field                             : visible cells [0:ROWS*COLS-1]
//   game_over/lines_cleared/busy      : status back to the game
// master = request source (game logic), slave = piece_drop_ctrl.
interface piece_drop_ctrl_if
  import tetris_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
);
  logic                   downTrue;
  logic                   moveLeft;
  logic                   moveRight;
  logic                   start;
  logic [0:ROWS*COLS-1]   field;
  logic                   game_over;
  logic [7:0]             lines_cleared;
  logic                   busy;

  modport master (
    output downTrue, moveLeft, moveRight, start,
    input  field, game_over, lines_cleared, busy
  );
  modport slave (
    input  downTrue, moveLeft, moveRight, start,
    output field, game_over, lines_cleared, busy
  );
endinterface

// File: rtl/collision_check.sv
// Combinational 2x2 placement test.
//   stack : settled cells
//   cand  : candidate top-left anchor (may be one step outside the field)
//   hit   : anchor out of range, or any of the four covered cells occupied
module collision_check
  import tetris_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic [0:ROWS*COLS-1] stack,
  input  anchor_t              cand,
  output logic                 hit
);
  localparam int IW = $clog2(ROWS * COLS);

  int candR, candC;
  assign candR = int'(cand.r);
  assign candC = int'(cand.c);

  always_comb begin
    hit = 1'b0;
    if (candR < 0 || candR > ROWS - 2 || candC < 0 || candC > COLS - 2) begin
      hit = 1'b1;
    end else begin
      for (int dr = 0; dr < 2; dr++)
        for (int dc = 0; dc < 2; dc++)
          if (stack[IW'(cell_idx(candR + dr, candC + dc, COLS))]) hit = 1'b1;
    end
  end
endmodule

// File: rtl/piece_drop_ctrl.sv
// Playfield owner: settled stack plus one falling 2x2 block.
//   clock_b : system clock (rising edge)
//   reset   : asynchronous, active-high
//   bus     : slave side of piece_drop_ctrl_if (requests in, field/status out)
// The block falls on downTrue, shifts on moveLeft/moveRight, locks on
// contact, full rows are removed one at a time by a bottom-up scan, and a
// blocked spawn ends the game until start.
module piece_drop_ctrl
  import tetris_pkg::*;
#(
  parameter int ROWS      = ROWS_DEF,
  parameter int COLS      = COLS_DEF,
  parameter int SPAWN_COL = 4
) (
  input  logic              clock_b,
  input  logic              reset,
  piece_drop_ctrl_if.slave  bus
);
  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N);
  localparam anchor_t SPAWN_ANC = '{r: 8'sd0, c: 8'(SPAWN_COL)};

  state_t     state, nextState;
  logic [0:N-1] stack, blockMask, shifted;
  anchor_t    anc;
  logic [7:0] scanRow;
  logic [7:0] lines;
  logic       rowFull;

  anchor_t downCand, leftCand, rightCand;
  logic    downHit, leftHit, rightHit, spawnHit;
  logic    doLeft, doRight;

  assign downCand  = '{r: anc.r + 8'sd1, c: anc.c};
  assign leftCand  = '{r: anc.r, c: anc.c - 8'sd1};
  assign rightCand = '{r: anc.r, c: anc.c + 8'sd1};

  collision_check #(.ROWS(ROWS), .COLS(COLS)) uDown  (.stack(stack), .cand(downCand),  .hit(downHit));
  collision_check #(.ROWS(ROWS), .COLS(COLS)) uLeft  (.stack(stack), .cand(leftCand),  .hit(leftHit));
  collision_check #(.ROWS(ROWS), .COLS(COLS)) uRight (.stack(stack), .cand(rightCand), .hit(rightHit));
  collision_check #(.ROWS(ROWS), .COLS(COLS)) uSpawn (.stack(stack), .cand(SPAWN_ANC), .hit(spawnHit));

  // A drop tick wins over lateral moves; opposing moves cancel.
  assign doLeft  = bus.moveLeft  && !bus.moveRight && !bus.downTrue && !leftHit;
  assign doRight = bus.moveRight && !bus.moveLeft  && !bus.downTrue && !rightHit;

  always_comb begin
    blockMask = '0;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        blockMask[IW'(cell_idx(int'(anc.r) + dr, int'(anc.c) + dc, COLS))] = 1'b1;
  end

  always_comb begin
    rowFull = 1'b1;
    for (int c = 0; c < COLS; c++)
      if (!stack[IW'(cell_idx(int'(scanRow), c, COLS))]) rowFull = 1'b0;
  end

  // Rows 1..scanRow pull from the row above; row 0 empties.
  always_comb begin
    shifted = stack;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (r == 0)
          shifted[IW'(cell_idx(0, c, COLS))] = 1'b0;
        else if (r <= int'(scanRow))
          shifted[IW'(cell_idx(r, c, COLS))] = stack[IW'(cell_idx(r - 1, c, COLS))];
  end

  // FSM: state register
  always_ff @(posedge clock_b or posedge reset)
    if (reset) state <= SPAWN;
    else       state <= nextState;

  // FSM: next state
  always_comb begin
    nextState = state;
    unique case (state)
      SPAWN:       nextState = spawnHit ? GAME_OVER : FALL;
      FALL:        if (bus.downTrue && downHit) nextState = LOCK;
      LOCK:        nextState = CLEAR_SCAN;
      CLEAR_SCAN:  if (rowFull) nextState = CLEAR_SHIFT;
                   else if (scanRow == 8'd0) nextState = SPAWN;
      CLEAR_SHIFT: nextState = CLEAR_SCAN;
      GAME_OVER:   if (bus.start) nextState = SPAWN;
      default:     nextState = SPAWN;
    endcase
  end

  // FSM: outputs (block only drawn while it is actually falling)
  always_comb begin
    bus.game_over     = (state == GAME_OVER);
    bus.busy          = state inside {LOCK, CLEAR_SCAN, CLEAR_SHIFT};
    bus.field         = (state == FALL) ? (stack | blockMask) : stack;
    bus.lines_cleared = lines;
  end

  // Datapath
  always_ff @(posedge clock_b or posedge reset)
    if (reset) begin
      stack   <= '0;
      anc     <= SPAWN_ANC;
      scanRow <= 8'(ROWS - 1);
      lines   <= 8'd0;
    end else begin
      case (state)
        SPAWN: anc <= SPAWN_ANC;
        FALL: begin
          if (bus.downTrue) begin
            if (!downHit) anc.r <= anc.r + 8'sd1;
          end else if (doLeft) begin
            anc.c <= anc.c - 8'sd1;
          end else if (doRight) begin
            anc.c <= anc.c + 8'sd1;
          end
        end
        LOCK: begin
          stack   <= stack | blockMask;
          scanRow <= 8'(ROWS - 1);
        end
        // Hold scanRow on a full row so the shifted-down row is re-tested.
        CLEAR_SCAN: if (!rowFull && scanRow != 8'd0) scanRow <= scanRow - 8'd1;
        CLEAR_SHIFT: begin
          stack <= shifted;
          lines <= lines + 8'd1;
        end
        GAME_OVER: if (bus.start) stack <= '0;
        default: ;
      endcase
    end
endmodule

// File: doc/piece_drop_ctrl.md
# piece_drop_ctrl

- Consumer of the periodic `downTrue` drop tick from the speed stage.
- Owns the 10x10 playfield: the settled stack plus one falling 2x2 block.
- Moves the block on drop ticks and left/right pulses, locks it on contact, clears full rows, and detects game over.
- Its `field` output feeds the VGA renderer.

## Interface
- `ROWS`, 10, playfield height in cells
- `COLS`, 10, playfield width in cells
- `SPAWN_COL`, 4, anchor column of a newly spawned block; must be ≤ COLS-2

- `clock_b`  in  1  system clock; all state is updated on the rising edge
- `reset`  in  1  asynchronous, active-high
- `downTrue`  in  1  one-cycle drop tick from the speed stage
- `moveLeft`  in  1  one-cycle request to shift the block one column left
- `moveRight`  in  1  one-cycle request to shift the block one column right
- `start`  in  1  one-cycle restart request; honoured only in GAME_OVER
- `field`  out  ROWS*COLS  visible cells, indexed [0:ROWS*COLS-1]
- `game_over`  out  1  high while in GAME_OVER
- `lines_cleared`  out  8  count of cleared rows, wraps modulo 256
- `busy`  out  1  high in LOCK, CLEAR_SCAN and CLEAR_SHIFT

## Operation

**Geometry**
- Cell (r,c) maps to index r*COLS+c; row 0 is the top row.
- The block anchor (ar,ac) is the block's top-left cell.
- The block covers (ar,ac), (ar,ac+1), (ar+1,ac) and (ar+1,ac+1).
- Legal anchor range: ar 0..ROWS-2, ac 0..COLS-2.

**Output**
- `field` = stack OR block mask.
- The block mask is applied only in FALL.
- `field` is combinational from registered state.

**States**
- SPAWN:
  - Load anchor (0,SPAWN_COL).
  - If any of the four cells is already set in the stack, go to GAME_OVER.
  - Otherwise go to FALL.
- FALL, on `downTrue`:
  - If ar==ROWS-2, or either cell in row ar+2 under the block is occupied, go to LOCK.
  - Otherwise ar ← ar+1.
- FALL, on `moveLeft`/`moveRight`:
  - Shift the anchor by ∓1 column.
  - The shift is made only if the new anchor is in range and both newly covered cells are free.
  - Otherwise the request is dropped silently.
- FALL, priorities:
  - If `downTrue` is high, lateral requests in that cycle are ignored.
  - If `moveLeft` and `moveRight` are both high, both are ignored.
- LOCK:
  - OR the four block cells into the stack.
  - Set the scan row to ROWS-1.
  - Go to CLEAR_SCAN.
- CLEAR_SCAN:
  - If every cell of the scan row is set, go to CLEAR_SHIFT.
  - Else if the scan row is 0, go to SPAWN.
  - Else decrement the scan row.
- CLEAR_SHIFT, in one cycle:
  - Each row 1..scan row takes the contents of the row above it.
  - Row 0 is zeroed.
  - `lines_cleared` increments.
  - The scan row is unchanged, so the same row is re-scanned next cycle.
  - Return to CLEAR_SCAN.
- GAME_OVER:
  - `field` shows the stack.
  - On `start`: clear the stack, leave `lines_cleared` unchanged, go to SPAWN.

**Dropped inputs**
- `downTrue`, `moveLeft` and `moveRight` outside FALL are dropped, not queued.
- `start` outside GAME_OVER is ignored.

## Timing
- Reset values:
  - state SPAWN
  - stack all-zero, anchor (0,SPAWN_COL), scan row ROWS-1
  - `field` 0, `game_over` 0, `lines_cleared` 0, `busy` 0
- The first cycle after reset deasserts is SPAWN. The block is visible in `field` from the following cycle.
- A tick or move accepted at edge N is reflected in `field` after edge N.
- Lock path:
  - The blocking tick moves the FSM to LOCK.
  - The stack is updated one edge later.
  - `busy` goes high in the cycle after the blocking tick.
- Scan duration:
  - CLEAR_SCAN takes ROWS cycles when no row is full.
  - Each full row adds 2 cycles (SHIFT plus re-scan).
- Reset asserted mid-clear aborts immediately to the reset values.
- `lines_cleared` wraps from 255 to 0.

## Structure
- Package `tetris_pkg` holds:
  - the state enum {SPAWN, FALL, LOCK, CLEAR_SCAN, CLEAR_SHIFT, GAME_OVER}
  - ROWS/COLS defaults
  - a `cell_idx(r,c)` function
- One combinational sub-module, `collision_check`:
  - inputs: stack, candidate anchor
  - output: `hit`, asserted if the anchor is out of range or any covered cell is occupied
  - shared by the down, left, right and spawn checks (three or four instances)

## Test plan
1. **Spawn and drop.** Release reset, then issue 8 `downTrue` ticks 5 cycles apart.
   - After spawn: `field` bits 4, 5, 14 and 15 are set.
   - After 8 ticks: anchor row 8, bits 84, 85, 94 and 95 set.
   - A 9th tick gives LOCK, then SPAWN after 10 scan cycles.
2. **Wall limits.** Issue 5 `moveLeft` pulses.
   - Anchor column reaches 0 after 4 pulses; the 5th is ignored.
   - `moveLeft` and `downTrue` in the same cycle: only the row changes.
3. **Line clear.**
   - Preload row 9 with columns 2..9 set and row 8 with column 5 set, via drops.
   - Drop a block at column 0 to the floor.
   - Result: row 9 clears, `lines_cleared`=1, and the former row 8 content appears in row 9.
4. **Double clear.**
   - Complete rows 8 and 9 with a single block.
   - Required: `lines_cleared` increases by 2, rows 8–9 end up empty, and scan-to-SPAWN takes 14 cycles.
5. **Game over and restart.**
   - Stack blocks at column 4 until the spawn cells are occupied.
   - Required: `game_over`=1, and ticks/moves leave `field` unchanged.
   - `start` clears the stack and respawns; `lines_cleared` is retained.
6. **Reset during clear.** Assert `reset` in CLEAR_SHIFT.
   - All outputs return to the reset values asynchronously.
